cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Schedules the two common data bus (CDB) broadcast slots among the functional-unit result producers: ALU RS, branch RS, load unit, store/misc unit.
- Each cycle it grants up to two pending results with round-robin fairness and registers them onto CDB slot 0 and slot 1 as one-cycle pulses.
- All reservation stations and the ROB snoop these pulses.
- Replaces ad-hoc per-unit driving of the CDB.

Parameters:
NREQ, 4, number of requesters (index 0..NREQ-1)
ROB_W, 6, ROB tag width
DATA_W, 32, result data width
INVALID_ROB, 6'b010000, "no tag" value; legal tags are 0..15

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
flush  input  1  synchronous mispredict flush; kills all acceptance this cycle
req_valid  input  NREQ  requester i has a result pending
req_rob  input  NREQ*ROB_W  tag of requester i, bits [i*ROB_W +: ROB_W]
req_data  input  NREQ*DATA_W  result of requester i, bits [i*DATA_W +: DATA_W]
req_ready  output  NREQ  combinational; result i is accepted at this rising edge
cdb0_valid  output  1  slot 0 broadcast pulse
cdb0_rob  output  ROB_W  slot 0 tag
cdb0_data  output  DATA_W  slot 0 data
cdb1_valid  output  1  slot 1 broadcast pulse
cdb1_rob  output  ROB_W  slot 1 tag
cdb1_data  output  DATA_W  slot 1 data
tag_err  output  1  registered pulse: a request with an illegal tag was discarded

Behaviour:
- Reset, asynchronous, all outputs and state:
  - cdb0_valid = cdb1_valid = 0.
  - cdb0_rob = cdb1_rob = INVALID_ROB.
  - cdb0_data = cdb1_data = 0.
  - tag_err = 0.
  - Round-robin pointer rr_ptr = 0.
- Reset mid-operation drops every un-broadcast grant. No requester state is held inside the block.
- Handshake:
  - A transfer occurs at a rising edge where req_valid[i] && req_ready[i].
  - The requester holds valid, rob and data stable until the transfer.
  - req_ready depends only on req_valid, req_rob, flush and rr_ptr. It never depends on req_data.
- Legal request: req_valid[i]=1 and req_rob[i] < 16.
- Illegal-tag request (req_rob[i] ≥ 16):
  - Gets req_ready[i]=1 in the same cycle, i.e. it is consumed.
  - Is never broadcast and takes no slot.
  - tag_err = 1 in the next cycle.
- Grant selection, combinational:
  - Scan legal requests in order rr_ptr, rr_ptr+1, … mod NREQ.
  - First legal request goes to slot 0, second to slot 1. Remaining requests get req_ready = 0.
- Latency: accepted at edge N, visible on cdbX_* during cycle N+1. Each broadcast is exactly a one-cycle pulse.
- Idle cycle: the next cycle has cdbX_valid = 0 and cdbX_rob = INVALID_ROB. cdbX_data holds its last value (don't-care).
- Slot 1 is valid only if slot 0 is valid. A single grant always uses slot 0.
- rr_ptr update:
  - If at least one legal grant: rr_ptr ← (index of the last legal request granted + 1) mod NREQ.
  - No legal grant: rr_ptr holds.
  - Illegal-tag consumption alone does not move rr_ptr.
- Fairness: a continuously valid legal requester is granted within ceil(NREQ/2) cycles.
- Flush = 1 at edge N:
  - All req_ready = 0 during that cycle; illegal-tag requests are not consumed either.
  - Cycle N+1: both cdbX_valid = 0, tags = INVALID_ROB.
  - rr_ptr ← 0.
  - A broadcast already on the CDB during cycle N (accepted at N-1) is not retracted.
- Two requesters with the same tag: both broadcast, in scan order. No dedup; the ROB guarantees tag uniqueness.
- Width: rr_ptr is clog2(NREQ) bits and wraps naturally. NREQ must be ≥ 2.

Test Plan:
- Reset then idle:
  - Stimulus: reset pulse mid-cycle, no requests.
  - Response: cdb0/1_valid = 0, tags = 6'd16, req_ready = 0000 for 5 cycles.
- Single request:
  - Stimulus: req_valid = 0010, req_rob[1] = 5, data = 32'hDEADBEEF.
  - Response: req_ready = 0010. Next cycle cdb0 = {1, 5, DEADBEEF}, cdb1_valid = 0. rr_ptr → 2.
- All four valid and held for 2 cycles, tags 1..4, rr_ptr = 0:
  - Cycle A: grants 0→slot0, 1→slot1.
  - Cycle B: grants 2→slot0, 3→slot1.
  - Broadcast tag order: 1, 2, 3, 4.
- Wrap-around:
  - Stimulus: rr_ptr = 3, req_valid = 1001.
  - Response: slot0 = req 3, slot1 = req 0, rr_ptr → 1.
- Illegal tag:
  - Stimulus: req_valid = 0101, req_rob[0] = 6'd16, req_rob[2] = 7.
  - Response: req_ready = 0101, only tag 7 broadcast on slot 0, tag_err pulse 1 cycle.
- Flush:
  - Stimulus: flush = 1 with req_valid = 1111.
  - Response: req_ready = 0000, next cycle no CDB valid, rr_ptr = 0. The following cycle grants 0 and 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to two legal results per cycle in round-robin
// order and registers them onto CDB slots 0 and 1 as single-cycle broadcast pulses.
module cdb_arbiter #(
   parameter int                NREQ        = 4,
   parameter int                ROB_W       = 6,
   parameter int                DATA_W      = 32,
   parameter logic [ROB_W-1:0]  INVALID_ROB = 6'b010000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ROB_W-1:0]    req_rob,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     cdb0_valid,
   output logic [ROB_W-1:0]         cdb0_rob,
   output logic [DATA_W-1:0]        cdb0_data,
   output logic                     cdb1_valid,
   output logic [ROB_W-1:0]         cdb1_rob,
   output logic [DATA_W-1:0]        cdb1_data,
   output logic                     tag_err
);

   localparam int PTR_W = $clog2(NREQ);

   logic [ROB_W-1:0]  rob_arr  [NREQ];
   logic [DATA_W-1:0] data_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign rob_arr[i]  = req_rob[i*ROB_W +: ROB_W];
      assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
   end

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_next;
   logic [PTR_W-1:0]  idx;
   logic [PTR_W-1:0]  last_idx;
   logic [PTR_W-1:0]  g0_idx;
   logic [PTR_W-1:0]  g1_idx;
   logic              g0_vld;
   logic              g1_vld;
   logic              bad_any;
   logic [NREQ-1:0]   ready_c;

   // Stage p0: combinational round-robin scan starting at rr_ptr
   always_comb begin
      ready_c  = '0;
      g0_vld   = 1'b0;
      g1_vld   = 1'b0;
      g0_idx   = '0;
      g1_idx   = '0;
      last_idx = '0;
      bad_any  = 1'b0;
      idx      = '0;
      if (!flush) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[idx]) begin
               if (rob_arr[idx] >= INVALID_ROB) begin
                  // Illegal tags are swallowed without consuming a slot.
                  ready_c[idx] = 1'b1;
                  bad_any      = 1'b1;
               end else if (!g0_vld) begin
                  ready_c[idx] = 1'b1;
                  g0_vld       = 1'b1;
                  g0_idx       = idx;
                  last_idx     = idx;
               end else if (!g1_vld) begin
                  ready_c[idx] = 1'b1;
                  g1_vld       = 1'b1;
                  g1_idx       = idx;
                  last_idx     = idx;
               end
            end
         end
      end
   end

   always_comb begin
      rr_next = rr_ptr;
      if (flush)
         rr_next = '0;
      else if (g0_vld)
         rr_next = PTR_W'((int'(last_idx) + 1) % NREQ);
   end

   assign req_ready = ready_c;

   logic              vld0_p1;
   logic [ROB_W-1:0]  rob0_p1;
   logic [DATA_W-1:0] data0_p1;
   logic              vld1_p1;
   logic [ROB_W-1:0]  rob1_p1;
   logic [DATA_W-1:0] data1_p1;
   logic              tag_err_p1;

   // Stage p1: registered CDB broadcast; data holds its last value when idle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld0_p1    <= 1'b0;
         rob0_p1    <= INVALID_ROB;
         data0_p1   <= '0;
         vld1_p1    <= 1'b0;
         rob1_p1    <= INVALID_ROB;
         data1_p1   <= '0;
         tag_err_p1 <= 1'b0;
         rr_ptr     <= '0;
      end else begin
         vld0_p1    <= g0_vld;
         rob0_p1    <= g0_vld ? rob_arr[g0_idx] : INVALID_ROB;
         vld1_p1    <= g1_vld;
         rob1_p1    <= g1_vld ? rob_arr[g1_idx] : INVALID_ROB;
         tag_err_p1 <= bad_any;
         rr_ptr     <= rr_next;
         if (g0_vld)
            data0_p1 <= data_arr[g0_idx];
         if (g1_vld)
            data1_p1 <= data_arr[g1_idx];
      end
   end

   assign cdb0_valid = vld0_p1;
   assign cdb0_rob   = rob0_p1;
   assign cdb0_data  = data0_p1;
   assign cdb1_valid = vld1_p1;
   assign cdb1_rob   = rob1_p1;
   assign cdb1_data  = data1_p1;
   assign tag_err    = tag_err_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter with hand-written sequences for
// reset, flush-without-retraction and asynchronous mid-operation reset.
module tb_cdb_arbiter;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [23:0]   req_rob = '0;
   logic [127:0]  req_data = '0;
   logic [3:0]    req_ready;
   logic          cdb0_valid, cdb1_valid, tag_err;
   logic [5:0]    cdb0_rob, cdb1_rob;
   logic [31:0]   cdb0_data, cdb1_data;

   cdb_arbiter dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_rob(req_rob), .req_data(req_data),
      .req_ready(req_ready),
      .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_data(cdb0_data),
      .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_data(cdb1_data),
      .tag_err(tag_err)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic         flush;
      logic [3:0]   valid;
      logic [23:0]  rob;
      logic [127:0] data;
      logic [3:0]   ready;
      logic         e0v;
      logic [5:0]   e0rob;
      logic [31:0]  e0d;
      logic         e1v;
      logic [5:0]   e1rob;
      logic [31:0]  e1d;
      logic         err;
   } vec_t;

   function automatic vec_t mkv(input logic fl, input logic [3:0] v, input logic [23:0] r,
                                input logic [127:0] d, input logic [3:0] rdy,
                                input logic e0v, input logic [5:0] e0r, input logic [31:0] e0d,
                                input logic e1v, input logic [5:0] e1r, input logic [31:0] e1d,
                                input logic err);
      vec_t t;
      t.flush = fl; t.valid = v; t.rob = r; t.data = d; t.ready = rdy;
      t.e0v = e0v; t.e0rob = e0r; t.e0d = e0d;
      t.e1v = e1v; t.e1rob = e1r; t.e1d = e1d; t.err = err;
      return t;
   endfunction

   localparam logic [31:0]  D0 = 32'h1111_0001;
   localparam logic [31:0]  D1 = 32'h2222_0002;
   localparam logic [31:0]  D2 = 32'h3333_0003;
   localparam logic [31:0]  D3 = 32'h4444_0004;
   localparam logic [127:0] DALL = {D3, D2, D1, D0};
   localparam logic [5:0]   NT = 6'd16;

   vec_t vecs[$];

   task automatic drive(input logic fl, input logic [3:0] v, input logic [23:0] r,
                        input logic [127:0] d);
      flush     = fl;
      req_valid = v;
      req_rob   = r;
      req_data  = d;
   endtask

   initial begin
      // Reset pulse mid-cycle, then idle
      #2 reset = 1'b1;
      #1;
      chk("rst_c0v", 32'(cdb0_valid), 32'd0);
      chk("rst_c0rob", 32'(cdb0_rob), 32'(NT));
      chk("rst_c0d", cdb0_data, 32'd0);
      chk("rst_c1rob", 32'(cdb1_rob), 32'(NT));
      chk("rst_c1d", cdb1_data, 32'd0);
      chk("rst_err", 32'(tag_err), 32'd0);
      #4 reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock); #1;
         chk("idle_ready", 32'(req_ready), 32'd0);
         chk("idle_c0v", 32'(cdb0_valid), 32'd0);
         chk("idle_c1v", 32'(cdb1_valid), 32'd0);
         chk("idle_c0rob", 32'(cdb0_rob), 32'(NT));
         chk("idle_c1rob", 32'(cdb1_rob), 32'(NT));
      end

      // Table: each row is one cycle; rr_ptr evolves from 0 through the sequence
      vecs.push_back(mkv(0, 4'b0000, '0, '0, 4'b0000, 0, NT, 0, 0, NT, 0, 0));
      vecs.push_back(mkv(0, 4'b0010, {6'd0, 6'd0, 6'd5, 6'd0}, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
                         4'b0010, 1, 6'd5, 32'hDEADBEEF, 0, NT, 0, 0));
      vecs.push_back(mkv(0, 4'b0100, {6'd0, 6'd9, 6'd0, 6'd0}, DALL, 4'b0100, 1, 6'd9, D2, 0, NT, 0, 0));
      vecs.push_back(mkv(0, 4'b1001, {6'd10, 6'd0, 6'd0, 6'd11}, DALL, 4'b1001, 1, 6'd10, D3, 1, 6'd11, D0, 0));
      vecs.push_back(mkv(0, 4'b1000, {6'd12, 6'd0, 6'd0, 6'd0}, DALL, 4'b1000, 1, 6'd12, D3, 0, NT, 0, 0));
      vecs.push_back(mkv(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, DALL, 4'b0011, 1, 6'd1, D0, 1, 6'd2, D1, 0));
      vecs.push_back(mkv(0, 4'b1100, {6'd4, 6'd3, 6'd2, 6'd1}, DALL, 4'b1100, 1, 6'd3, D2, 1, 6'd4, D3, 0));
      vecs.push_back(mkv(0, 4'b0101, {6'd0, 6'd7, 6'd0, 6'd16}, DALL, 4'b0101, 1, 6'd7, D2, 0, NT, 0, 1));
      vecs.push_back(mkv(0, 4'b0000, '0, DALL, 4'b0000, 0, NT, 0, 0, NT, 0, 0));
      vecs.push_back(mkv(1, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, DALL, 4'b0000, 0, NT, 0, 0, NT, 0, 0));
      vecs.push_back(mkv(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, DALL, 4'b0011, 1, 6'd1, D0, 1, 6'd2, D1, 0));
      vecs.push_back(mkv(0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd20}, DALL, 4'b0001, 0, NT, 0, 0, NT, 0, 1));
      vecs.push_back(mkv(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, DALL, 4'b1100, 1, 6'd3, D2, 1, 6'd4, D3, 0));
      vecs.push_back(mkv(1, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd16}, DALL, 4'b0000, 0, NT, 0, 0, NT, 0, 0));
      vecs.push_back(mkv(0, 4'b0110, {6'd0, 6'd6, 6'd6, 6'd0}, DALL, 4'b0110, 1, 6'd6, D1, 1, 6'd6, D2, 0));

      foreach (vecs[i]) begin
         @(negedge clock);
         drive(vecs[i].flush, vecs[i].valid, vecs[i].rob, vecs[i].data);
         #1;
         chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
         @(posedge clock); #1;
         chk($sformatf("v%0d_c0v", i), 32'(cdb0_valid), 32'(vecs[i].e0v));
         chk($sformatf("v%0d_c0rob", i), 32'(cdb0_rob), 32'(vecs[i].e0rob));
         chk($sformatf("v%0d_c1v", i), 32'(cdb1_valid), 32'(vecs[i].e1v));
         chk($sformatf("v%0d_c1rob", i), 32'(cdb1_rob), 32'(vecs[i].e1rob));
         chk($sformatf("v%0d_err", i), 32'(tag_err), 32'(vecs[i].err));
         if (vecs[i].e0v) chk($sformatf("v%0d_c0d", i), cdb0_data, vecs[i].e0d);
         if (vecs[i].e1v) chk($sformatf("v%0d_c1d", i), cdb1_data, vecs[i].e1d);
      end

      // Flush does not retract a broadcast already on the bus (rr_ptr is 3 here)
      @(negedge clock);
      drive(0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd3}, DALL);
      #1 chk("fl_pre_ready", 32'(req_ready), 32'b0001);
      @(negedge clock);
      drive(1, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, DALL);
      #1;
      chk("fl_ready", 32'(req_ready), 32'd0);
      chk("fl_keep_c0v", 32'(cdb0_valid), 32'd1);
      chk("fl_keep_c0rob", 32'(cdb0_rob), 32'd3);
      chk("fl_keep_c0d", cdb0_data, D0);
      @(posedge clock); #1;
      chk("fl_after_c0v", 32'(cdb0_valid), 32'd0);
      chk("fl_after_c0rob", 32'(cdb0_rob), 32'(NT));
      @(negedge clock);
      drive(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, DALL);
      #1 chk("fl_next_ready", 32'(req_ready), 32'b0011);

      // Asynchronous reset mid-operation drops the pending broadcast
      @(posedge clock); #1;
      chk("ar_pre_c1v", 32'(cdb1_valid), 32'd1);
      drive(0, 4'b0000, '0, '0);
      #1 reset = 1'b1;
      #1;
      chk("ar_c0v", 32'(cdb0_valid), 32'd0);
      chk("ar_c1v", 32'(cdb1_valid), 32'd0);
      chk("ar_c0rob", 32'(cdb0_rob), 32'(NT));
      chk("ar_c1d", cdb1_data, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      drive(0, 4'b1100, {6'd4, 6'd3, 6'd2, 6'd1}, DALL);
      #1 chk("ar_rr0_ready", 32'(req_ready), 32'b1100);
      @(posedge clock); #1;
      chk("ar_rr0_c0rob", 32'(cdb0_rob), 32'd3);
      @(negedge clock);
      drive(0, 4'b0000, '0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
